// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg
//   Shared constants for the status-LED arbiter: display mode codes, FSM state
//   encoding, default prescaler tap positions and the round-robin index helper.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_DARK   = 2'd0;
    localparam logic [1:0] MODE_STEADY = 2'd1;
    localparam logic [1:0] MODE_FAST   = 2'd2;
    localparam logic [1:0] MODE_SLOW   = 2'd3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    localparam int DEF_SLOW_BIT = 23;
    localparam int DEF_FAST_BIT = 21;

    // Circular index: (base + offset) mod n, valid for base, offset < n.
    function automatic int rr_index(input int base, input int offset, input int n);
        int s;
        s = base + offset;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler
//   Free-running PRESCALE_W-bit counter with synchronous clear. Produces the
//   raw count (used for blink taps) and period_tick, high in the last cycle of
//   every 2^(SLOW_BIT+1)-cycle period.
//   clk          in   system clock
//   clr          in   synchronous clear (reset or command accept)
//   cnt          out  current count
//   period_tick  out  cnt[SLOW_BIT:0] all ones
module led_prescaler
    import led_ctrl_pkg::*;
#(
    parameter int PRESCALE_W = 24,
    parameter int SLOW_BIT   = DEF_SLOW_BIT
) (
    input  logic                  clk,
    input  logic                  clr,
    output logic [PRESCALE_W-1:0] cnt,
    output logic                  period_tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt         = cnt_q;
    assign period_tick = &cnt_q[SLOW_BIT:0];

endmodule

// File: rtl/led_status_arbiter.sv
// led_status_arbiter
//   Shares the 4 board status LEDs between NUM_REQ requesters. Commands
//   (mode, mask, duration in periods) are accepted round-robin over a
//   valid/ready handshake, displayed for their duration, then followed by one
//   dark cooldown period. With no command active, led[0] shows a heartbeat.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   req_valid  in   per-requester command valid
//   req_mode   in   per-requester mode, slice i = [2i+1:2i]
//   req_mask   in   per-requester LED mask, slice i = [4i+3:4i]
//   req_count  in   per-requester duration in periods (0 treated as 1)
//   req_ready  out  one-hot acceptance pulse
//   grant_id   out  index of the active / last granted requester
//   busy       out  high in ACTIVE or COOLDOWN
//   led        out  registered LED drive
//
//   state    | meaning
//   IDLE     | heartbeat on led[0], arbitrating requests
//   ACTIVE   | showing latched command, counting down periods
//   COOLDOWN | LEDs dark for one full period before re-arbitration
module led_status_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int PRESCALE_W = 24,
    parameter int SLOW_BIT   = DEF_SLOW_BIT,
    parameter int FAST_BIT   = DEF_FAST_BIT,
    parameter int CNT_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [2*NUM_REQ-1:0]       req_mode,
    input  logic [4*NUM_REQ-1:0]       req_mask,
    input  logic [CNT_W*NUM_REQ-1:0]   req_count,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [3:0]                 led
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [1:0]       mode_arr [NUM_REQ];
    logic [3:0]       mask_arr [NUM_REQ];
    logic [CNT_W-1:0] cnt_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign mode_arr[g] = req_mode[2*g +: 2];
        assign mask_arr[g] = req_mask[4*g +: 4];
        assign cnt_arr[g]  = req_count[CNT_W*g +: CNT_W];
    end

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       mask_q, mask_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [3:0]       led_q, led_d;

    logic [PRESCALE_W-1:0] presc;
    logic                  period_tick;
    logic                  presc_unused;
    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic [ID_W-1:0]       cand;
    logic                  accept;

    // Accept also clears the prescaler so every command starts on a period boundary.
    led_prescaler #(
        .PRESCALE_W (PRESCALE_W),
        .SLOW_BIT   (SLOW_BIT)
    ) u_presc (
        .clk         (clk),
        .clr         (rst | accept),
        .cnt         (presc),
        .period_tick (period_tick)
    );

    assign presc_unused = ^presc;

    // First valid requester at or after rr_ptr, searching circularly.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'(rr_index(int'(rr_ptr_q), i, NUM_REQ));
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign accept    = (state_q == ST_IDLE) && win_found && !rst;
    assign req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        rem_d    = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_ACTIVE;
                    grant_d  = win_idx;
                    rr_ptr_d = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                    mode_d   = mode_arr[win_idx];
                    mask_d   = mask_arr[win_idx];
                    rem_d    = (cnt_arr[win_idx] == '0) ? CNT_W'(1) : cnt_arr[win_idx];
                end
            end
            ST_ACTIVE: begin
                if (period_tick) begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_COOLDOWN;
                    end else begin
                        rem_d = rem_q - 1'b1;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (period_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        led_d = 4'b0000;
        case (state_q)
            ST_IDLE: led_d = {3'b000, presc[SLOW_BIT]};
            ST_ACTIVE: begin
                case (mode_q)
                    MODE_DARK:   led_d = 4'b0000;
                    MODE_STEADY: led_d = mask_q;
                    MODE_FAST:   led_d = mask_q & {4{presc[FAST_BIT]}};
                    default:     led_d = mask_q & {4{presc[SLOW_BIT]}};
                endcase
            end
            default: led_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            mode_q   <= MODE_DARK;
            mask_q   <= '0;
            rem_q    <= '0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            rem_q    <= rem_d;
            led_q    <= led_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign led      = led_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
// tb_led_status_arbiter
//   Scoreboard bench: expected grants are queued when a request is driven; on
//   each observed req_ready pulse the monitor pops the grant and queues the
//   cycle-by-cycle expected led/busy/grant_id trace derived from the command.
module tb_led_status_arbiter;

    localparam int NR  = 4;
    localparam int PW  = 8;
    localparam int SB  = 3;
    localparam int FB  = 1;
    localparam int CW  = 4;
    localparam int PER = 1 << (SB + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [2*NR-1:0]   req_mode;
    logic [4*NR-1:0]   req_mask;
    logic [CW*NR-1:0]  req_count;
    logic [NR-1:0]     req_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic [3:0]        led;

    always #5 clk = ~clk;

    led_status_arbiter #(
        .NUM_REQ    (NR),
        .PRESCALE_W (PW),
        .SLOW_BIT   (SB),
        .FAST_BIT   (FB),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_mask  (req_mask),
        .req_count (req_count),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .led       (led)
    );

    typedef struct {
        int         id;
        int         mode;
        logic [3:0] mask;
        int         cnt;
        int         tail;
    } grant_t;

    typedef struct {
        logic [3:0] led;
        bit         chk_led;
        logic       busy;
        logic [1:0] gid;
    } obs_t;

    grant_t exp_grant_q[$];
    obs_t   exp_obs_q[$];

    int n_cmp  = 0;
    int n_err  = 0;
    bit mon_en = 1'b0;
    int cyc    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] pattern(input int mode, input logic [3:0] mask, input int k);
        case (mode)
            0:       return 4'b0000;
            1:       return mask;
            2:       return mask & {4{k[FB]}};
            default: return mask & {4{k[SB]}};
        endcase
    endfunction

    // Trace starts at T+1 (accept cycle T). From T+2 on, the prescaler seen
    // by the LED register equals k, so the pattern is a function of k alone.
    task automatic push_trace(input grant_t g);
        int   n;
        obs_t o;
        n = (g.cnt == 0) ? 1 : g.cnt;
        o = '{4'h0, 1'b0, 1'b1, 2'(g.id)};
        exp_obs_q.push_back(o);
        for (int k = 0; k < n*PER; k++) begin
            o = '{pattern(g.mode, g.mask, k), 1'b1, 1'b1, 2'(g.id)};
            exp_obs_q.push_back(o);
        end
        for (int k = n*PER; k < (n+1)*PER; k++) begin
            o = '{4'h0, 1'b1, (k != (n+1)*PER - 1), 2'(g.id)};
            exp_obs_q.push_back(o);
        end
        for (int k = (n+1)*PER; k < (n+1)*PER + g.tail; k++) begin
            o = '{{3'b000, k[SB]}, 1'b1, 1'b0, 2'(g.id)};
            exp_obs_q.push_back(o);
        end
    endtask

    always @(negedge clk) begin
        obs_t   o;
        grant_t g;
        cyc++;
        if (mon_en) begin
            if (exp_obs_q.size() > 0) begin
                o = exp_obs_q.pop_front();
                if (o.chk_led) check_val("led", led, o.led);
                check_val("busy", busy, o.busy);
                check_val("grant_id", grant_id, o.gid);
            end
            if (req_ready != '0) begin
                if (exp_grant_q.size() == 0) begin
                    check_val("unexpected_ready", req_ready, 0);
                end else begin
                    g = exp_grant_q.pop_front();
                    check_val("req_ready", req_ready, 1 << g.id);
                    push_trace(g);
                end
            end
        end
    end

    task automatic set_req(input int id, input int mode, input logic [3:0] mask, input int cnt);
        req_mode[2*id +: 2]    = 2'(mode);
        req_mask[4*id +: 4]    = mask;
        req_count[CW*id +: CW] = CW'(cnt);
    endtask

    task automatic issue(input int id, input int mode, input logic [3:0] mask, input int cnt, input int tail);
        grant_t g;
        g = '{id, mode, mask, cnt, tail};
        exp_grant_q.push_back(g);
        set_req(id, mode, mask, cnt);
        req_valid[id] = 1'b1;
    endtask

    task automatic wait_ready(input int id);
        int t;
        t = 0;
        while (req_ready[id] !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check_val("ready_timeout", req_ready, 1 << id);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_obs_q.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) check_val("drain_timeout", exp_obs_q.size(), 0);
    endtask

    task automatic run_cmd(input int id, input int mode, input logic [3:0] mask, input int cnt, input int tail);
        @(posedge clk);
        #1;
        issue(id, mode, mask, cnt, tail);
        wait_ready(id);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        int   t;
        int   st[4];
        obs_t o;

        rst       = 1'b1;
        req_valid = '1;
        req_mode  = '0;
        req_mask  = '0;
        req_count = '0;

        // Reset held with every requester valid: nothing may be granted.
        @(negedge clk);
        check_val("rst_led", led, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", req_ready, 0);
        check_val("rst_grant_id", grant_id, 0);
        @(negedge clk);
        check_val("rst_ready2", req_ready, 0);
        check_val("rst_led2", led, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        // Heartbeat: prescaler was 0 in the first free cycle, LED lags by one.
        for (int j = 0; j < 3*(PER/2) + 1; j++) begin
            o.led     = (j == 0) ? 4'h0 : 4'(((j - 1) >> SB) & 1);
            o.chk_led = 1'b1;
            o.busy    = 1'b0;
            o.gid     = 2'd0;
            exp_obs_q.push_back(o);
        end
        mon_en = 1'b1;
        drain();

        run_cmd(0, 1, 4'b1010, 2, PER);   // STEADY, then heartbeat tail
        run_cmd(1, 2, 4'b1111, 1, 0);     // FAST
        run_cmd(3, 1, 4'b0101, 0, 0);     // count 0 behaves as 1

        // Round robin: 0 and 2 held valid, rr_ptr is back at 0.
        @(posedge clk);
        #1;
        issue(0, 1, 4'b0011, 1, 0);
        issue(2, 1, 4'b1100, 1, 0);
        issue(0, 1, 4'b0011, 1, 0);
        issue(2, 1, 4'b1100, 1, 0);
        seen = 0;
        t    = 0;
        while (seen < 4 && t < 600) begin
            @(negedge clk);
            t++;
            if (req_ready != '0) begin
                st[seen] = t;
                seen++;
            end
        end
        if (seen < 4) begin
            check_val("rr_timeout", seen, 4);
        end else begin
            // 32 busy cycles between pulses plus the IDLE accept cycle.
            for (int i = 1; i < 4; i++) check_val("rr_pitch", st[i] - st[i-1], 2*PER + 1);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // Mid-command reset during a SLOW command on requester 2.
        @(posedge clk);
        #1;
        issue(2, 3, 4'b1111, 3, 0);
        wait_ready(2);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_obs_q.delete();
        exp_grant_q.delete();
        @(negedge clk);
        check_val("midrst_led", led, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_grant_id", grant_id, 0);
        mon_en = 1'b1;

        // rr_ptr must be 0 again: requester 0 beats requester 3.
        @(posedge clk);
        #1;
        issue(0, 1, 4'b1001, 1, 0);
        set_req(3, 1, 4'b0110, 1);
        req_valid[3] = 1'b1;
        wait_ready(0);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
